// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch FSM states and the canonical NOP.
package cpu_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Parametric synchronous FIFO for fetched {instr, pc} pairs.
// The head is presented combinationally; a same-cycle push and pop are both
// honoured even when full, and flush empties the FIFO while ignoring any pop.
module instr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // Unwritten storage is never visible: the head reads as zero while empty.
  assign head = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the array has no reset; occupancy alone decides validity, so it maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding imem read at a time, responses
// buffered with their pc in instr_fifo for decode.
// Optional build macro FETCH_ALIGN_CHECK_EN: a misaligned pc raises fetch_fault
// instead of issuing a request; the fault holds until flush or rst.
module instr_fetch_unit #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_advance,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            fetch_fault
`endif
);

  import cpu_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LAST = FIFO_DEPTH - 1;
  localparam logic [CW-1:0] LAST_SLOT = LAST[CW-1:0];

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [XLEN-1:0]   addr_q;
  logic              rsp_push;
  logic              start_req;
  logic              if_pop;
  logic              room_after_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [2*XLEN-1:0] fifo_head;
  logic              fault_q;
`ifdef FETCH_ALIGN_CHECK_EN
  logic              fault_set;
`endif

  instr_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data ({imem_rsp_data, addr_q}),
    .pop       (if_ready),
    .flush     (flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign if_valid  = !fifo_empty;
  assign if_instr  = fifo_head[2*XLEN-1:XLEN];
  assign if_pc     = fifo_head[XLEN-1:0];
  assign imem_addr = addr_q;
  assign if_pop    = if_valid && if_ready && !flush;

  // In WAIT the in-flight slot is already reserved, so the FIFO holds at most
  // DEPTH-1 entries; after the push there is room unless it was the last slot.
  assign room_after_push = (fifo_count != LAST_SLOT) || if_pop;

  // Next-state and handshake outputs; flush overrides every transition.
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt      = state;
    pc_advance     = 1'b0;
    imem_req_valid = 1'b0;
    rsp_push       = 1'b0;
    start_req      = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_set      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!flush && !fifo_full && !fault_q) start_req = 1'b1;
      end
      REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          // An accepted request is in flight even if flush hits this cycle.
          pc_advance = 1'b1;
          state_nxt  = flush ? DROP : WAIT;
        end else if (flush) begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (flush) begin
            state_nxt = IDLE;
          end else begin
            rsp_push = 1'b1;
            if (room_after_push) start_req = 1'b1;
            else                 state_nxt = IDLE;
          end
        end else if (flush) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (start_req) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (pc[1:0] != 2'b00) begin
        fault_set = 1'b1;
        state_nxt = IDLE;
      end else
`endif
      begin
        state_nxt = REQ;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request address: sampled from pc on REQ entry, stable until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 addr_q <= '0;
    else if (state_nxt == REQ && state != REQ) addr_q <= pc;
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky misalignment fault, cleared only by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            fault_q <= 1'b0;
    else if (flush)     fault_q <= 1'b0;
    else if (fault_set) fault_q <= 1'b1;
  end

  assign fetch_fault = fault_q;
`else
  assign fault_q = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: next-PC model, instruction memory
// model with configurable latency, and a scoreboard of expected {pc, instr}.
// Build with FETCH_ALIGN_CHECK_EN to include the alignment-fault scenario.
module tb_instr_fetch_unit;

  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_advance;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  instr_fetch_unit #(
    .XLEN       (32),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_advance     (pc_advance),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ NOP_INSTR;
  endfunction

  task automatic push_exp(input logic [31:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = mem_word(p);
    sb.push_back(e);
  endtask

  // Next-PC logic model: redirect on request, else step by 4 after pc_advance.
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = 32'h0;
  always @(posedge clk or posedge rst) begin
    if (rst)             pc <= 32'h0;
    else if (pc_load)    pc <= pc_load_val;
    else if (pc_advance) pc <= pc + 32'd4;
  end

  // Instruction memory: response rsp_lat cycles after the acceptance cycle.
  int          rsp_lat = 0;
  bit          bad_data_next = 1'b0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  int          acc_count = 0;
  logic        mem_acc;
  logic [31:0] mem_a;
  always @(posedge clk) begin
    mem_acc = imem_req_valid && imem_req_ready && !rst;
    mem_a   = imem_addr;
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (rst) pend = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = bad_data_next ? 32'hDEAD_BEEF : mem_word(pend_addr);
        bad_data_next  = 1'b0;
        pend           = 1'b0;
      end
    end
    if (mem_acc) begin
      acc_count++;
      pend      = 1'b1;
      pend_cnt  = rsp_lat;
      pend_addr = mem_a;
      if (rsp_lat == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = bad_data_next ? 32'hDEAD_BEEF : mem_word(pend_addr);
        bad_data_next  = 1'b0;
        pend           = 1'b0;
      end
    end
  end

  // Scoreboard consumer and request-side protocol checks (pre-edge values).
  always @(posedge clk) begin
    if (!rst) begin
      if (if_valid && if_ready && !flush) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pop: got pc=%h instr=%h, no instruction expected", if_pc, if_instr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (if_pc !== e.pc || if_instr !== e.instr) begin
            errors++;
            $display("FAIL fetch_order: got pc=%h instr=%h, expected pc=%h instr=%h",
                     if_pc, if_instr, e.pc, e.instr);
          end
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (imem_addr !== pc) begin
          errors++;
          $display("FAIL req_addr: got %h, expected %h", imem_addr, pc);
        end
      end
      if (pc_advance || (imem_req_valid && imem_req_ready)) begin
        checks++;
        if (pc_advance !== (imem_req_valid && imem_req_ready)) begin
          errors++;
          $display("FAIL pc_advance_pulse: got %b, expected %b", pc_advance,
                   imem_req_valid && imem_req_ready);
        end
      end
    end
  end

  task automatic do_flush(input logic [31:0] target, input logic rdy);
    @(negedge clk);
    flush       = 1'b1;
    pc_load     = 1'b1;
    pc_load_val = target;
    if_ready    = rdy;
    @(negedge clk);
    flush   = 1'b0;
    pc_load = 1'b0;
    sb.delete();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d entries still pending after %0d cycles, expected 0", name, sb.size(), n);
    end
  endtask

  task automatic test_reset;
    rst            = 1'b1;
    flush          = 1'b0;
    if_ready       = 1'b0;
    imem_req_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (pc_advance !== 1'b0)     begin errors++; $display("FAIL reset_pc_advance: got %b, expected 0", pc_advance); end
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b, expected 0", imem_req_valid); end
    if (if_valid !== 1'b0)       begin errors++; $display("FAIL reset_if_valid: got %b, expected 0", if_valid); end
    if (imem_addr !== 32'h0)     begin errors++; $display("FAIL reset_imem_addr: got %h, expected 0", imem_addr); end
    if (if_instr !== 32'h0)      begin errors++; $display("FAIL reset_if_instr: got %h, expected 0", if_instr); end
    if (if_pc !== 32'h0)         begin errors++; $display("FAIL reset_if_pc: got %h, expected 0", if_pc); end
`ifdef FETCH_ALIGN_CHECK_EN
    checks++;
    if (fetch_fault !== 1'b0)    begin errors++; $display("FAIL reset_fetch_fault: got %b, expected 0", fetch_fault); end
`endif
  endtask

  task automatic test_stream;
    rsp_lat        = 0;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    rst      = 1'b0;
    if_ready = 1'b1;
    wait_drain("stream");
  endtask

  task automatic test_backpressure;
    int acc0;
    do_flush(32'h0, 1'b0);
    acc0 = acc_count;
    repeat (12) @(negedge clk);
    checks += 3;
    if (acc_count - acc0 != 2) begin errors++; $display("FAIL bp_requests: got %0d, expected 2", acc_count - acc0); end
    if (if_valid !== 1'b1)     begin errors++; $display("FAIL bp_if_valid: got %b, expected 1", if_valid); end
    if (if_pc !== 32'h0)       begin errors++; $display("FAIL bp_head_pc: got %h, expected 0", if_pc); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_held: got %b, expected 0", imem_req_valid); end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    if_ready = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_req_stall;
    int n;
    imem_req_ready = 1'b0;
    do_flush(32'h40, 1'b1);
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_req_valid: got %b, expected 1", imem_req_valid); end
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (imem_addr !== 32'h40) begin errors++; $display("FAIL stall_addr: got %h, expected 00000040", imem_addr); end
      if (pc_advance !== 1'b0)  begin errors++; $display("FAIL stall_pc_advance: got %b, expected 0", pc_advance); end
      @(negedge clk);
    end
    push_exp(32'h40);
    push_exp(32'h44);
    push_exp(32'h48);
    imem_req_ready = 1'b1;
    #1;
    checks++;
    if (pc_advance !== 1'b1) begin errors++; $display("FAIL stall_accept_pulse: got %b, expected 1", pc_advance); end
    wait_drain("req_stall");
  endtask

  task automatic test_flush_wait;
    int n;
    rsp_lat = 3;
    do_flush(32'h80, 1'b0);
    n = 0;
    while (pc_advance !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (pc_advance !== 1'b1) begin errors++; $display("FAIL fw_accept: got %b, expected 1", pc_advance); end
    @(negedge clk);
    flush         = 1'b1;
    pc_load       = 1'b1;
    pc_load_val   = 32'h100;
    bad_data_next = 1'b1;
    @(negedge clk);
    flush   = 1'b0;
    pc_load = 1'b0;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 12) begin
      checks++;
      if (if_valid !== 1'b0) begin errors++; $display("FAIL fw_if_valid: got %b, expected 0", if_valid); end
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL fw_redirect_addr: got %h, expected 00000100", imem_addr); end
    rsp_lat = 0;
    push_exp(32'h100);
    push_exp(32'h104);
    if_ready = 1'b1;
    wait_drain("flush_wait");
  endtask

  task automatic test_flush_full_pop;
    repeat (8) @(negedge clk);
    checks += 2;
    if (if_valid !== 1'b1)       begin errors++; $display("FAIL ffp_full_valid: got %b, expected 1", if_valid); end
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL ffp_full_req: got %b, expected 0", imem_req_valid); end
    do_flush(32'h200, 1'b1);
    checks += 2;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL ffp_empty: got %b, expected 0", if_valid); end
    if (if_pc !== 32'h0)   begin errors++; $display("FAIL ffp_head_pc: got %h, expected 0", if_pc); end
    push_exp(32'h200);
    push_exp(32'h204);
    push_exp(32'h208);
    wait_drain("flush_full_pop");
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align;
    int acc0;
    do_flush(32'h102, 1'b0);
    acc0 = acc_count;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks += 2;
      if (fetch_fault !== 1'b1)    begin errors++; $display("FAIL align_fault: got %b, expected 1", fetch_fault); end
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL align_no_req: got %b, expected 0", imem_req_valid); end
      @(negedge clk);
    end
    checks++;
    if (acc_count != acc0) begin errors++; $display("FAIL align_requests: got %0d, expected 0", acc_count - acc0); end
    do_flush(32'h104, 1'b1);
    checks++;
    if (fetch_fault !== 1'b0) begin errors++; $display("FAIL align_clear: got %b, expected 0", fetch_fault); end
    push_exp(32'h104);
    push_exp(32'h108);
    wait_drain("align");
  endtask
`endif

  task automatic test_reset_mid;
    int n;
    rsp_lat = 2;
    do_flush(32'h300, 1'b0);
    n = 0;
    while (pc_advance !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_req_valid: got %b, expected 0", imem_req_valid); end
    if (if_valid !== 1'b0)       begin errors++; $display("FAIL rmid_if_valid: got %b, expected 0", if_valid); end
    if (imem_addr !== 32'h0)     begin errors++; $display("FAIL rmid_imem_addr: got %h, expected 0", imem_addr); end
    if (pc_advance !== 1'b0)     begin errors++; $display("FAIL rmid_pc_advance: got %b, expected 0", pc_advance); end
    repeat (3) @(negedge clk);
    rsp_lat = 0;
    push_exp(32'h0);
    push_exp(32'h4);
    rst      = 1'b0;
    if_ready = 1'b1;
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_flush_wait();
    test_flush_full_pop();
`ifdef FETCH_ALIGN_CHECK_EN
    test_align();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, test sequence incomplete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter register.
- Samples the current pc and issues one instruction-memory read at a time over a valid/ready request channel.
- Captures each response, with its pc, into a small FIFO that feeds decode over a valid/ready handshake.
- Pulses pc_advance to the next-PC logic when a request is accepted; supports a flush for branch/jump redirects.

Parameters:
- XLEN, 32, width of pc, address and instruction.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- pc  in  XLEN  current pc from the program counter register
- pc_advance  out  1  one-cycle pulse when a fetch request is accepted
- flush  in  1  discard buffered and in-flight instructions
- imem_req_valid  out  1  memory read request valid
- imem_req_ready  in  1  memory accepts the request
- imem_addr  out  XLEN  request address
- imem_rsp_valid  in  1  read data valid, one cycle
- imem_rsp_data  in  XLEN  read data
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts the instruction
- if_instr  out  XLEN  instruction at FIFO head
- if_pc  out  XLEN  pc of if_instr
- fetch_fault  out  1  misaligned-pc flag; present only with the optional feature

Behaviour:
- Reset (async, active-high, clk domain):
  - FSM goes to IDLE and the FIFO empties.
  - pc_advance, imem_req_valid, if_valid and fetch_fault are 0.
  - imem_addr, if_instr and if_pc are 0.
- FSM states: IDLE, REQ, WAIT, DROP.
  - IDLE -> REQ when there is FIFO space, counting the slot reserved for the in-flight response.
  - REQ:
    - imem_req_valid=1; imem_addr is registered from pc on REQ entry and held stable until accepted.
    - On imem_req_ready: pc_advance=1 that same cycle, then go to WAIT.
  - WAIT: on imem_rsp_valid, push {imem_rsp_data, imem_addr} into the FIFO. Then go to REQ if space remains after the push, else IDLE.
  - DROP: wait for the outstanding response, discard it, then go to IDLE.
- At most one request is outstanding. Throughput is one instruction per two cycles with a zero-wait memory.
- The next request uses the pc value present on REQ entry. Next-PC logic updates pc on the clk edge following pc_advance.
- FIFO:
  - Head is presented combinationally on if_instr/if_pc; if_valid = not empty.
  - Pop occurs on if_valid && if_ready.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full (pop frees the slot).
  - Pointers wrap modulo FIFO_DEPTH.
  - No push is ever issued when full. Space reservation guarantees this, so the response never needs backpressure.
- Flush (highest priority, synchronous):
  - The FIFO empties the next cycle; a pop in the flush cycle is ignored.
  - From REQ before acceptance: drop imem_req_valid and go to IDLE.
  - Acceptance in the flush cycle: the request counts as in flight; pc_advance still pulses; go to DROP.
  - From WAIT: go to DROP, unless imem_rsp_valid arrives the same cycle, in which case discard it and go to IDLE.
  - pc is redirected externally; this block holds no redirect target.
- Reset mid-transaction returns the FSM to IDLE. Any late memory response is ignored because imem_rsp_valid is only honoured in WAIT/DROP.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN
- Defined: on REQ entry with pc[1:0]!=0, no request is issued.
  - fetch_fault is set, and the FSM holds in IDLE with pc_advance=0.
  - fetch_fault clears only on flush or rst.
- Undefined: no alignment check; the fetch_fault port is absent; pc[1:0] passes through to imem_addr unchanged.

Decomposition:
- Shared package cpu_pkg:
  - XLEN constant.
  - Fetch FSM state enum (IDLE, REQ, WAIT, DROP).
  - NOP instruction constant 32'h00000013 for bench fill.
- One sub-module: instr_fifo (parametric sync FIFO with push/pop/flush/full/empty, data width 2*XLEN).

Test Plan:
- Zero-wait memory, if_ready=1, pc stepping by 4 from 0: the bench sees if_pc 0,4,8,... with if_instr matching memory contents, and one pc_advance per request.
- if_ready=0: exactly FIFO_DEPTH=2 instructions buffer, then imem_req_valid stays 0. Raising if_ready drains pcs 0,4 in order and fetching resumes at pc 8.
- imem_req_ready held low 3 cycles at pc=0x40: imem_addr stays 0x40, and pc_advance is 0 until the acceptance cycle.
- Flush during WAIT (rsp arrives 2 cycles later with 0xDEADBEEF): the response is discarded and if_valid stays 0. Next fetch is from the redirected pc 0x100.
- Flush in the same cycle as a pop with the FIFO full: the FIFO is empty next cycle with no duplicate or lost pop side effects.
- With FETCH_ALIGN_CHECK_EN, pc=0x102: fetch_fault=1 with no request; a flush with pc=0x104 clears the fault and the fetch proceeds.
